load_store_unit: RTL and testbench
==================================

# load_store_unit

MEM-stage load/store unit between the EX/MEM pipeline register and the MEM/WB register. It takes the ALU-computed address, forwarded store data and funct3 for a memory instruction and runs a request/acknowledge transaction on a word-wide data bus with byte enables. It stalls the pipeline until the bus responds and returns sign- or zero-extended load data for write-back. It replaces the single-cycle combinational data-memory read with a handshake that tolerates variable-latency memory.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum WAIT cycles without bus_ack before the access is aborted (range 2..255).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX/MEM slot holds a valid instruction
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store
- funct3  in  3  access type: 000 b, 001 h, 010 w, 100 bu, 101 hu
- address  in  32  byte address (ALU result)
- store_data  in  32  forwarded rs2 value
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- load_data  out  32  extended load result, registered
- load_valid  out  1  one-cycle pulse: load_data updated
- misaligned  out  1  one-cycle pulse: access rejected for alignment
- fault  out  1  one-cycle pulse: timeout or illegal request
- bus_req  out  1  bus request, held until bus_ack
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, {address[31:2], 2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated write data
- bus_ack  in  1  bus completes the access this cycle
- bus_rdata  in  32  read word, valid with bus_ack

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE, op = ex_valid & (mem_read | mem_write):
  - op with both mem_read and mem_write set: no bus access, fault pulse next cycle, stay IDLE.
  - op misaligned (w with address[1:0] != 0; h/hu with address[0] = 1): no bus access, misaligned pulse next cycle, stall = 0, stay IDLE.
  - op legal: latch bus_addr/bus_we/bus_be/bus_wdata/funct3/address[1:0], stall = 1 combinationally this cycle, go to WAIT.
  - funct3 011/110/111: treated as an illegal request (fault).
- WAIT: bus_req = 1, all bus outputs stable, stall = 1, timeout counter increments.
  - bus_ack: capture and extend rdata for loads, go to DONE.
  - counter reaches TIMEOUT_CYCLES: drop bus_req, load_data = 0, fault pulse, go to DONE.
- DONE: stall = 0, load_valid = 1 for loads only. Go to IDLE. The same instruction is not re-accepted because EX/MEM advances at the end of DONE.
- Byte enables:
  - sb: 4'b0001 << address[1:0]
  - sh: 4'b0011 when address[1] = 0, else 4'b1100
  - sw: 4'b1111
  - loads: 4'b1111
- Write data: sb replicates {4{store_data[7:0]}}; sh replicates {2{store_data[15:0]}}; sw passes store_data.
- Load extraction: shift bus_rdata right by 8·address[1:0], then sign-extend (b, h) or zero-extend (bu, hu) from bit 7 or bit 15. w passes the word unchanged.
- bus_ack outside WAIT is ignored.
- load_data holds its value until the next load completes.

## Timing
- Reset (reset = 0, async): state IDLE, counter 0. stall, load_valid, misaligned, fault, bus_req, bus_we are 0. bus_addr, bus_be, bus_wdata, load_data are 0. bus_req drops immediately, including mid-transaction, and the in-flight access is abandoned.
- Accept cycle C0 (IDLE, stall = 1). bus_req is first high in C1. With bus_ack in cycle Ck, DONE is Ck+1, and load_valid and the new load_data are visible in Ck+1.
- Minimum stall is 2 cycles (ack in C1); the pipeline advances at the end of Ck+1.
- Timeout: with no ack, bus_req is high for exactly TIMEOUT_CYCLES cycles, then fault pulses in DONE.
- Alignment and illegal-request rejections cost 0 stall cycles; the pulse appears the cycle after the instruction occupies EX/MEM.
- Non-memory instructions (ex_valid = 0, or neither mem_read nor mem_write) leave the FSM in IDLE with all pulses 0.

## Test plan
- lw, address 0x14, bus_ack 3 cycles after bus_req, rdata 0x0000006D -> bus_be 1111, bus_addr 0x14, stall high 4 cycles, load_valid with load_data 0x0000006D.
- lb, address 0x17, rdata 0x80FF1234 -> load_data 0xFFFFFF80. Same access as lbu -> 0x00000080.
- sh, address 0x22, store_data 0xDEADBEEF, ack in C1 -> bus_we 1, bus_addr 0x20, bus_be 1100, bus_wdata 0xBEEFBEEF, no load_valid, stall high 2 cycles.
- lw, address 0x16 -> no bus_req, misaligned pulse, stall never asserted. lh at address 0x13 behaves the same way.
- lw with bus_ack never asserted, TIMEOUT_CYCLES = 4 -> bus_req high exactly 4 cycles, then fault pulse, load_data 0, stall released.
- reset pulled low during WAIT -> bus_req and stall go to 0 without waiting for clk. After release, a new sw at address 0x00 completes normally, and a stray bus_ack arriving in IDLE is ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns a memory instruction into a req/ack bus transaction,
// stalls the pipeline while the bus is busy and returns extended load data for write-back.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] address,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        misaligned,
   output logic        fault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [3:0]  bus_be_q, bus_be_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] load_data_q, load_data_d;
   logic        load_valid_q, load_valid_d;
   logic        misaligned_q, misaligned_d;
   logic        fault_q, fault_d;

   logic        op_s, illegal_s, mis_s, accept_s;

   function automatic logic [3:0] be_f(input logic is_store, input logic [2:0] f3,
                                       input logic [1:0] off);
      logic [3:0] be;
      if (!is_store) begin
         be = 4'b1111;
      end else begin
         case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
         endcase
      end
      return be;
   endfunction

   function automatic logic [31:0] wdata_f(input logic [2:0] f3, input logic [31:0] data);
      logic [31:0] w;
      case (f3[1:0])
         2'b00:   w = {4{data[7:0]}};
         2'b01:   w = {2{data[15:0]}};
         default: w = data;
      endcase
      return w;
   endfunction

   // Bring the addressed byte/half down to bit 0, then sign- or zero-extend.
   function automatic logic [31:0] extend_f(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] rdata);
      logic [31:0] sh;
      logic [31:0] r;
      sh = rdata >> {off, 3'b000};
      case (f3)
         3'b000:  r = {{24{sh[7]}}, sh[7:0]};
         3'b001:  r = {{16{sh[15]}}, sh[15:0]};
         3'b100:  r = {24'h000000, sh[7:0]};
         3'b101:  r = {16'h0000, sh[15:0]};
         default: r = rdata;
      endcase
      return r;
   endfunction

   assign op_s      = ex_valid & (mem_read | mem_write);
   assign illegal_s = op_s & ((mem_read & mem_write) | (funct3 == 3'b011) | (funct3[2:1] == 2'b11));
   assign mis_s     = op_s & ~illegal_s &
                      (((funct3[1:0] == 2'b10) & (address[1:0] != 2'b00)) |
                       ((funct3[1:0] == 2'b01) & address[0]));
   assign accept_s  = op_s & ~illegal_s & ~mis_s;

   // Stall is combinational so the accept cycle already freezes the pipeline.
   assign stall = reset & (((state_q == S_IDLE) & accept_s) | (state_q == S_WAIT));

   // Next-state, bus latching and response pulse generation.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bus_req_d    = bus_req_q;
      bus_we_d     = bus_we_q;
      bus_addr_d   = bus_addr_q;
      bus_be_d     = bus_be_q;
      bus_wdata_d  = bus_wdata_q;
      f3_d         = f3_q;
      off_d        = off_q;
      load_data_d  = load_data_q;
      load_valid_d = 1'b0;
      misaligned_d = 1'b0;
      fault_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (illegal_s) begin
               fault_d = 1'b1;
            end else if (mis_s) begin
               misaligned_d = 1'b1;
            end else if (accept_s) begin
               bus_req_d   = 1'b1;
               bus_we_d    = mem_write;
               bus_addr_d  = {address[31:2], 2'b00};
               bus_be_d    = be_f(mem_write, funct3, address[1:0]);
               bus_wdata_d = wdata_f(funct3, store_data);
               f3_d        = funct3;
               off_d       = address[1:0];
               cnt_d       = 8'd0;
               state_d     = S_WAIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (bus_ack) begin
               bus_req_d = 1'b0;
               state_d   = S_DONE;
               if (!bus_we_q) begin
                  load_data_d  = extend_f(f3_q, off_q, bus_rdata);
                  load_valid_d = 1'b1;
               end else begin
                  load_valid_d = 1'b0;
               end
            end else if (cnt_q == TMO_LAST) begin
               bus_req_d = 1'b0;
               fault_d   = 1'b1;
               state_d   = S_DONE;
               if (!bus_we_q) begin
                  load_data_d  = 32'h0000_0000;
                  load_valid_d = 1'b1;
               end else begin
                  load_valid_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d   = S_IDLE;
            bus_req_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any in-flight access.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 8'd0;
         bus_req_q    <= 1'b0;
         bus_we_q     <= 1'b0;
         bus_addr_q   <= 32'h0000_0000;
         bus_be_q     <= 4'b0000;
         bus_wdata_q  <= 32'h0000_0000;
         f3_q         <= 3'b000;
         off_q        <= 2'b00;
         load_data_q  <= 32'h0000_0000;
         load_valid_q <= 1'b0;
         misaligned_q <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bus_req_q    <= bus_req_d;
         bus_we_q     <= bus_we_d;
         bus_addr_q   <= bus_addr_d;
         bus_be_q     <= bus_be_d;
         bus_wdata_q  <= bus_wdata_d;
         f3_q         <= f3_d;
         off_q        <= off_d;
         load_data_q  <= load_data_d;
         load_valid_q <= load_valid_d;
         misaligned_q <= misaligned_d;
         fault_q      <= fault_d;
      end
   end

   assign bus_req    = bus_req_q;
   assign bus_we     = bus_we_q;
   assign bus_addr   = bus_addr_q;
   assign bus_be     = bus_be_q;
   assign bus_wdata  = bus_wdata_q;
   assign load_data  = load_data_q;
   assign load_valid = load_valid_q;
   assign misaligned = misaligned_q;
   assign fault      = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected bus/response/stall
// records, a negedge monitor pops and compares them as the DUT produces events.
module tb_load_store_unit;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ex_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] address = 32'h0, store_data = 32'h0;
   logic        stall, load_valid, misaligned, fault, bus_req, bus_we;
   logic [31:0] load_data, bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = 32'h0;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      bit          chk_wd;
      int          len;
   } bus_exp_t;

   typedef struct {
      logic        lv;
      logic        flt;
      logic        mis;
      logic [31:0] data;
   } resp_exp_t;

   bus_exp_t  bus_q[$];
   resp_exp_t resp_q[$];
   int        stall_q[$];

   load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .mem_read(mem_read),
      .mem_write(mem_write), .funct3(funct3), .address(address), .store_data(store_data),
      .stall(stall), .load_data(load_data), .load_valid(load_valid),
      .misaligned(misaligned), .fault(fault), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic exp_bus(input logic we, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input bit chk, input int len);
      bus_exp_t e;
      e.we = we; e.addr = a; e.be = be; e.wdata = wd; e.chk_wd = chk; e.len = len;
      bus_q.push_back(e);
   endtask

   task automatic exp_resp(input logic lv, input logic flt, input logic mis, input logic [31:0] d);
      resp_exp_t e;
      e.lv = lv; e.flt = flt; e.mis = mis; e.data = d;
      resp_q.push_back(e);
   endtask

   // k = ack cycle after accept (1..TMO), 0 = never ack; reject = alignment/illegal.
   task automatic drive_op(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input int k,
                           input logic [31:0] rdata, input bit reject);
      int n;
      @(posedge clk); #1;
      ex_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
      address = a; store_data = sd; bus_rdata = rdata; bus_ack = 1'b0;
      if (!reject) begin
         n = (k == 0) ? TMO : k;
         for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            bus_ack = (k != 0) && (i == k);
         end
         @(posedge clk); #1;
         bus_ack = 1'b0;
      end
      @(posedge clk); #1;
      ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      @(posedge clk); #1;
   endtask

   // Monitor: bus transactions, stall run lengths and response pulses.
   bus_exp_t cur_bus;
   int  breq_len = 0, stall_len = 0;
   logic breq_prev = 1'b0, stall_prev = 1'b0;

   always @(negedge clk) begin
      if (bus_req) begin
         if (!breq_prev) begin
            check("bus_expected", 32'(bus_q.size() != 0), 32'd1);
            if (bus_q.size() != 0) begin
               cur_bus = bus_q.pop_front();
               check("bus_we", {31'd0, bus_we}, {31'd0, cur_bus.we});
               check("bus_addr", bus_addr, cur_bus.addr);
               check("bus_be", {28'd0, bus_be}, {28'd0, cur_bus.be});
               if (cur_bus.chk_wd) check("bus_wdata", bus_wdata, cur_bus.wdata);
            end else begin
               cur_bus.len = -1;
            end
            breq_len = 1;
         end else begin
            breq_len++;
         end
      end else if (breq_prev && cur_bus.len >= 0) begin
         check("bus_req_cycles", 32'(breq_len), 32'(cur_bus.len));
      end
      breq_prev = bus_req;

      if (stall) begin
         stall_len = stall_prev ? stall_len + 1 : 1;
      end else if (stall_prev) begin
         check("stall_expected", 32'(stall_q.size() != 0), 32'd1);
         if (stall_q.size() != 0) begin
            int e;
            e = stall_q.pop_front();
            if (e >= 0) check("stall_cycles", 32'(stall_len), 32'(e));
         end
      end
      stall_prev = stall;

      if (load_valid || fault || misaligned) begin
         check("resp_expected", 32'(resp_q.size() != 0), 32'd1);
         if (resp_q.size() != 0) begin
            resp_exp_t r;
            r = resp_q.pop_front();
            check("resp_lv_flt_mis", {29'd0, load_valid, fault, misaligned},
                  {29'd0, r.lv, r.flt, r.mis});
            check("load_data", load_data, r.data);
         end
      end
   end

   initial begin
      #12;
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_load_valid", {31'd0, load_valid}, 32'd0);
      check("rst_misaligned", {31'd0, misaligned}, 32'd0);
      check("rst_fault", {31'd0, fault}, 32'd0);
      check("rst_bus_req", {31'd0, bus_req}, 32'd0);
      check("rst_bus_we", {31'd0, bus_we}, 32'd0);
      check("rst_bus_addr", bus_addr, 32'd0);
      check("rst_bus_be", {28'd0, bus_be}, 32'd0);
      check("rst_bus_wdata", bus_wdata, 32'd0);
      check("rst_load_data", load_data, 32'd0);
      @(negedge clk); reset = 1'b1;

      // lw 0x14, ack 3 cycles into the request
      exp_bus(1'b0, 32'h14, 4'b1111, 32'h0, 1'b0, 3); stall_q.push_back(4);
      exp_resp(1'b1, 1'b0, 1'b0, 32'h0000006D);
      drive_op(1'b1, 1'b0, 3'b010, 32'h14, 32'h0, 3, 32'h0000006D, 1'b0);
      // lb / lbu at 0x17
      exp_bus(1'b0, 32'h14, 4'b1111, 32'h0, 1'b0, 1); stall_q.push_back(2);
      exp_resp(1'b1, 1'b0, 1'b0, 32'hFFFFFF80);
      drive_op(1'b1, 1'b0, 3'b000, 32'h17, 32'h0, 1, 32'h80FF1234, 1'b0);
      exp_bus(1'b0, 32'h14, 4'b1111, 32'h0, 1'b0, 1); stall_q.push_back(2);
      exp_resp(1'b1, 1'b0, 1'b0, 32'h00000080);
      drive_op(1'b1, 1'b0, 3'b100, 32'h17, 32'h0, 1, 32'h80FF1234, 1'b0);
      // sh 0x22
      exp_bus(1'b1, 32'h20, 4'b1100, 32'hBEEFBEEF, 1'b1, 1); stall_q.push_back(2);
      drive_op(1'b0, 1'b1, 3'b001, 32'h22, 32'hDEADBEEF, 1, 32'h0, 1'b0);
      // misaligned lw 0x16 and lh 0x13; load_data holds
      exp_resp(1'b0, 1'b0, 1'b1, 32'h00000080);
      drive_op(1'b1, 1'b0, 3'b010, 32'h16, 32'h0, 0, 32'h0, 1'b1);
      exp_resp(1'b0, 1'b0, 1'b1, 32'h00000080);
      drive_op(1'b1, 1'b0, 3'b001, 32'h13, 32'h0, 0, 32'h0, 1'b1);
      // sb 0x1A
      exp_bus(1'b1, 32'h18, 4'b0100, 32'hA5A5A5A5, 1'b1, 2); stall_q.push_back(3);
      drive_op(1'b0, 1'b1, 3'b000, 32'h1A, 32'h000000A5, 2, 32'h0, 1'b0);
      // lh / lhu 0x12; lhu acks in the last allowed cycle
      exp_bus(1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, 2); stall_q.push_back(3);
      exp_resp(1'b1, 1'b0, 1'b0, 32'hFFFF8001);
      drive_op(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 2, 32'h80017FFF, 1'b0);
      exp_bus(1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, TMO); stall_q.push_back(TMO + 1);
      exp_resp(1'b1, 1'b0, 1'b0, 32'h00008001);
      drive_op(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, TMO, 32'h80017FFF, 1'b0);
      // illegal: read+write, funct3 011
      exp_resp(1'b0, 1'b1, 1'b0, 32'h00008001);
      drive_op(1'b1, 1'b1, 3'b010, 32'h20, 32'h0, 0, 32'h0, 1'b1);
      exp_resp(1'b0, 1'b1, 1'b0, 32'h00008001);
      drive_op(1'b1, 1'b0, 3'b011, 32'h20, 32'h0, 0, 32'h0, 1'b1);
      // sw 0x0C
      exp_bus(1'b1, 32'h0C, 4'b1111, 32'h12345678, 1'b1, 1); stall_q.push_back(2);
      drive_op(1'b0, 1'b1, 3'b010, 32'h0C, 32'h12345678, 1, 32'h0, 1'b0);
      // timeout lw
      exp_bus(1'b0, 32'h40, 4'b1111, 32'h0, 1'b0, TMO); stall_q.push_back(TMO + 1);
      exp_resp(1'b1, 1'b1, 1'b0, 32'h0);
      drive_op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 0, 32'hFFFFFFFF, 1'b0);

      // async reset during WAIT
      exp_bus(1'b0, 32'h30, 4'b1111, 32'h0, 1'b0, -1); stall_q.push_back(-1);
      @(posedge clk); #1;
      ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; address = 32'h30;
      @(posedge clk); #1;
      @(posedge clk); #3;
      reset = 1'b0; ex_valid = 1'b0; mem_read = 1'b0;
      #1;
      check("async_rst_bus_req", {31'd0, bus_req}, 32'd0);
      check("async_rst_stall", {31'd0, stall}, 32'd0);
      @(negedge clk); reset = 1'b1;

      exp_bus(1'b1, 32'h00, 4'b1111, 32'hCAFEF00D, 1'b1, 2); stall_q.push_back(3);
      drive_op(1'b0, 1'b1, 3'b010, 32'h00, 32'hCAFEF00D, 2, 32'h0, 1'b0);
      // stray ack in IDLE
      @(posedge clk); #1; bus_ack = 1'b1; bus_rdata = 32'h5555AAAA;
      @(posedge clk); #1; bus_ack = 1'b0;
      check("stray_ack_load_valid", {31'd0, load_valid}, 32'd0);
      check("stray_ack_load_data", load_data, 32'd0);
      check("stray_ack_bus_req", {31'd0, bus_req}, 32'd0);
      repeat (4) @(posedge clk);
      #1;
      check("bus_q_left", 32'(bus_q.size()), 32'd0);
      check("resp_q_left", 32'(resp_q.size()), 32'd0);
      check("stall_q_left", 32'(stall_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
